// File: rtl/voice_alloc_ctrl.sv
// Polyphonic voice allocator: maps MIDI note events onto oscillator voices
// (free-first, retrigger, oldest-steal) and writes ROM phase steps to the voice bank.
module voice_alloc_ctrl #(
  parameter int NUM_VOICES = 8,
  parameter int VOICE_W    = 3,
  parameter int AGE_W      = 4,
  parameter int STEP_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ev_valid_i,
  output logic                  ev_ready_o,
  input  logic                  ev_on_i,
  input  logic [6:0]            ev_note_i,
  input  logic [6:0]            ev_vel_i,
  output logic [6:0]            rom_addr_o,
  input  logic [STEP_W-1:0]     rom_step_i,
  output logic                  voice_wr_o,
  output logic [VOICE_W-1:0]    voice_idx_o,
  output logic [STEP_W-1:0]     voice_step_o,
  output logic                  voice_gate_o,
  output logic [6:0]            voice_vel_o,
  output logic [NUM_VOICES-1:0] active_o
);

  typedef enum logic [1:0] {IDLE, SEARCH, LOOKUP, WRITE} state_t;

  localparam logic [AGE_W-1:0] AgeMax = {AGE_W{1'b1}};

  state_t                  state_q;
  logic                    evOn_q;
  logic [6:0]              evNote_q;
  logic [6:0]              evVel_q;
  logic [VOICE_W-1:0]      target_q;
  logic [NUM_VOICES-1:0]   active_q;
  logic [6:0]              note_q [NUM_VOICES];
  logic [AGE_W-1:0]        age_q  [NUM_VOICES];
  logic [6:0]              romAddr_q;
  logic                    voiceWr_q;
  logic [VOICE_W-1:0]      voiceIdx_q;
  logic [STEP_W-1:0]       voiceStep_q;
  logic                    voiceGate_q;
  logic [6:0]              voiceVel_q;

  logic                    hasMatch;
  logic                    hasFree;
  logic [VOICE_W-1:0]      matchIdx;
  logic [VOICE_W-1:0]      freeIdx;
  logic [VOICE_W-1:0]      oldestIdx;
  logic [AGE_W-1:0]        bestAge;
  logic [VOICE_W-1:0]      target_d;
  logic                    drop_d;

  // Descending scan leaves the lowest qualifying index; strict '>' keeps the lowest on age ties.
  always_comb begin
    hasMatch  = 1'b0;
    hasFree   = 1'b0;
    matchIdx  = '0;
    freeIdx   = '0;
    oldestIdx = '0;
    bestAge   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (active_q[v] && (note_q[v] == evNote_q)) begin
        hasMatch = 1'b1;
        matchIdx = VOICE_W'(v);
      end
      if (!active_q[v]) begin
        hasFree = 1'b1;
        freeIdx = VOICE_W'(v);
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (age_q[v] > bestAge) begin
        bestAge   = age_q[v];
        oldestIdx = VOICE_W'(v);
      end
    end
    if (evOn_q) begin
      target_d = hasMatch ? matchIdx : (hasFree ? freeIdx : oldestIdx);
    end else begin
      target_d = matchIdx;
    end
    drop_d = !evOn_q && !hasMatch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      evOn_q      <= 1'b0;
      evNote_q    <= '0;
      evVel_q     <= '0;
      target_q    <= '0;
      active_q    <= '0;
      romAddr_q   <= '0;
      voiceWr_q   <= 1'b0;
      voiceIdx_q  <= '0;
      voiceStep_q <= '0;
      voiceGate_q <= 1'b0;
      voiceVel_q  <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      voiceWr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ev_valid_i) begin
            evOn_q    <= ev_on_i && (ev_vel_i != 7'd0);
            evNote_q  <= ev_note_i;
            evVel_q   <= ev_vel_i;
            romAddr_q <= ev_note_i;
            state_q   <= SEARCH;
          end
        end
        SEARCH: begin
          target_q <= target_d;
          state_q  <= drop_d ? IDLE : LOOKUP;
        end
        LOOKUP: begin
          voiceWr_q   <= 1'b1;
          voiceIdx_q  <= target_q;
          voiceStep_q <= rom_step_i;
          voiceGate_q <= evOn_q;
          voiceVel_q  <= evOn_q ? evVel_q : 7'd0;
          // Table moves on the same edge that raises the write strobe.
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (VOICE_W'(v) == target_q) begin
              active_q[v] <= evOn_q;
              age_q[v]    <= '0;
              if (evOn_q) begin
                note_q[v] <= evNote_q;
              end
            end else if (evOn_q && active_q[v] && (age_q[v] != AgeMax)) begin
              age_q[v] <= age_q[v] + 1'b1;
            end
          end
          state_q <= WRITE;
        end
        WRITE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ev_ready_o   = (state_q == IDLE);
  assign rom_addr_o   = romAddr_q;
  assign voice_wr_o   = voiceWr_q;
  assign voice_idx_o  = voiceIdx_q;
  assign voice_step_o = voiceStep_q;
  assign voice_gate_o = voiceGate_q;
  assign voice_vel_o  = voiceVel_q;
  assign active_o     = active_q;

endmodule

// File: tb/tb_voice_alloc_ctrl.sv
// Scoreboard bench for voice_alloc_ctrl: directed events push expected voice writes,
// a negedge monitor pops and compares each voice_wr_o strobe.
module tb_voice_alloc_ctrl;

  logic        clk;
  logic        rst;
  logic        ev_valid_i;
  logic        ev_ready_o;
  logic        ev_on_i;
  logic [6:0]  ev_note_i;
  logic [6:0]  ev_vel_i;
  logic [6:0]  rom_addr_o;
  logic [31:0] rom_step_i;
  logic        voice_wr_o;
  logic [2:0]  voice_idx_o;
  logic [31:0] voice_step_o;
  logic        voice_gate_o;
  logic [6:0]  voice_vel_o;
  logic [7:0]  active_o;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] step;
    logic        gate;
    logic [6:0]  vel;
    logic [7:0]  active;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  voice_alloc_ctrl #(
    .NUM_VOICES(8),
    .VOICE_W   (3),
    .AGE_W     (4),
    .STEP_W    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_valid_i  (ev_valid_i),
    .ev_ready_o  (ev_ready_o),
    .ev_on_i     (ev_on_i),
    .ev_note_i   (ev_note_i),
    .ev_vel_i    (ev_vel_i),
    .rom_addr_o  (rom_addr_o),
    .rom_step_i  (rom_step_i),
    .voice_wr_o  (voice_wr_o),
    .voice_idx_o (voice_idx_o),
    .voice_step_o(voice_step_o),
    .voice_gate_o(voice_gate_o),
    .voice_vel_o (voice_vel_o),
    .active_o    (active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Equal-tempered step table referenced to A4 = 1999899; notes outside 21..108 read 0.
  function automatic logic [31:0] romStep(input logic [6:0] note);
    real r;
    if (note < 7'd21 || note > 7'd108) return 32'd0;
    r = 1999899.0 * (2.0 ** ((real'(int'(note)) - 69.0) / 12.0));
    return 32'($rtoi(r + 0.5));
  endfunction

  always @(posedge clk) rom_step_i <= romStep(rom_addr_o);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  always @(negedge clk) begin
    if (voice_wr_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWrite: got idx %0d gate %0d, expected no write",
                 voice_idx_o, voice_gate_o);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("voiceIdx",  32'(voice_idx_o),  32'(e.idx));
        checkOutput("voiceStep", voice_step_o,      e.step);
        checkOutput("voiceGate", 32'(voice_gate_o), 32'(e.gate));
        checkOutput("voiceVel",  32'(voice_vel_o),  32'(e.vel));
        checkOutput("activeMap", 32'(active_o),     32'(e.active));
      end
    end
  end

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    ev_valid_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic applyStimulus(input bit on, input logic [6:0] note, input logic [6:0] vel,
                               input bit expWr, input logic [2:0] expIdx,
                               input logic [31:0] expStep, input logic [7:0] expActive,
                               input bit hold);
    int w;
    exp_t e;
    @(negedge clk);
    ev_valid_i = 1'b1;
    ev_on_i    = on;
    ev_note_i  = note;
    ev_vel_i   = vel;
    w = 0;
    while (!ev_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ev_ready_o) begin
      checkOutput("readyTimeout", 32'(ev_ready_o), 32'd1);
      ev_valid_i = 1'b0;
      return;
    end
    if (expWr) begin
      e.idx    = expIdx;
      e.step   = expStep;
      e.gate   = on && (vel != 7'd0);
      e.vel    = (on && (vel != 7'd0)) ? vel : 7'd0;
      e.active = expActive;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) ev_valid_i = 1'b0;
  endtask

  initial begin
    int cnt;
    rst        = 1'b1;
    ev_valid_i = 1'b0;
    ev_on_i    = 1'b0;
    ev_note_i  = '0;
    ev_vel_i   = '0;

    // Reset state
    doReset(3);
    @(negedge clk);
    checkOutput("rstActive", 32'(active_o),   32'd0);
    checkOutput("rstReady",  32'(ev_ready_o), 32'd1);
    checkOutput("rstWr",     32'(voice_wr_o), 32'd0);
    checkOutput("rstRomAddr",32'(rom_addr_o), 32'd0);

    // Single note-on: address, latency and ready return
    applyStimulus(1'b1, 7'd69, 7'd100, 1'b1, 3'd0, 32'd1999899, 8'h01, 1'b0);
    @(negedge clk);
    checkOutput("romAddr69", 32'(rom_addr_o), 32'd69);
    checkOutput("busyReady", 32'(ev_ready_o), 32'd0);
    cnt = 1;
    while (!voice_wr_o && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("wrLatency", 32'(cnt), 32'd3);
    @(negedge clk);
    checkOutput("readyAfterWr", 32'(ev_ready_o), 32'd1);
    checkOutput("wrOneCycle",   32'(voice_wr_o), 32'd0);

    // Fill all voices, then steal the oldest
    doReset(2);
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1'b1, 7'(60 + n), 7'(10 + n), 1'b1, 3'(n), romStep(7'(60 + n)),
                    8'((16'h1 << (n + 1)) - 1), 1'b0);
    end
    applyStimulus(1'b1, 7'd72, 7'd90, 1'b1, 3'd0, 32'd2378294, 8'hFF, 1'b0);

    // Note-off of active and inactive notes
    applyStimulus(1'b0, 7'd61, 7'd33, 1'b1, 3'd1, romStep(7'd61), 8'hFD, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 7'd50, 7'd20, 1'b0, 3'd0, 32'd0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("dropBusy",  32'(ev_ready_o), 32'd0);
    @(negedge clk);
    checkOutput("dropReady", 32'(ev_ready_o), 32'd1);

    // Velocity-zero note-on releases; repeated note retriggers
    applyStimulus(1'b1, 7'd64, 7'd0,  1'b1, 3'd4, romStep(7'd64), 8'hED, 1'b0);
    applyStimulus(1'b1, 7'd65, 7'd77, 1'b1, 3'd5, romStep(7'd65), 8'hED, 1'b0);
    // Free voices first, then steal the voice whose age was not reset by the retrigger
    applyStimulus(1'b1, 7'd70, 7'd41, 1'b1, 3'd1, romStep(7'd70), 8'hEF, 1'b0);
    applyStimulus(1'b1, 7'd71, 7'd42, 1'b1, 3'd4, romStep(7'd71), 8'hFF, 1'b0);
    applyStimulus(1'b1, 7'd73, 7'd43, 1'b1, 3'd2, romStep(7'd73), 8'hFF, 1'b0);
    repeat (5) @(negedge clk);

    // Reset during LOOKUP discards the event
    applyStimulus(1'b1, 7'd60, 7'd50, 1'b0, 3'd0, 32'd0, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstActive", 32'(active_o),   32'd0);
    checkOutput("midRstReady",  32'(ev_ready_o), 32'd1);
    checkOutput("midRstWr",     32'(voice_wr_o), 32'd0);
    repeat (4) @(negedge clk);

    // Back-to-back events with valid held high
    applyStimulus(1'b1, 7'd60, 7'd21, 1'b1, 3'd0, romStep(7'd60), 8'h01, 1'b1);
    applyStimulus(1'b1, 7'd61, 7'd22, 1'b1, 3'd1, romStep(7'd61), 8'h03, 1'b1);
    applyStimulus(1'b1, 7'd62, 7'd23, 1'b1, 3'd2, romStep(7'd62), 8'h07, 1'b0);

    cnt = 0;
    while (expQ.size() != 0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    repeat (4) @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
